// File: rtl/imu_regs_pkg.sv
// Purpose: shared register-map constants and state encoding for the IMU SPI responder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package imu_regs_pkg;

    localparam logic [7:0] WHO_AM_I      = 8'h6C;
    localparam logic [6:0] WHO_AM_I_ADDR = 7'h0F;

    localparam logic [6:0] CTRL_BASE  = 7'h10;
    localparam int         CTRL_COUNT = 10;
    localparam logic [6:0] OUT_BASE   = 7'h22;
    localparam int         OUT_BYTES  = 12;

    // Addresses the init/burst-read master actually touches.
    localparam logic [6:0] CTRL1_XL_ADDR = 7'h10;
    localparam logic [6:0] CTRL2_G_ADDR  = 7'h11;
    localparam logic [6:0] CTRL4_C_ADDR  = 7'h13;
    localparam logic [6:0] CTRL9_XL_ADDR = 7'h18;
    localparam logic [6:0] OUTX_L_G_ADDR = 7'h22;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } rsp_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Purpose: 2-FF synchronisers for SPC/CS/SDI plus edge flags derived from the synced copies.
// Latency: edge flags assert 2-3 clk after the raw pin edge (two sync stages plus history).
// Backpressure: none; pins are sampled every cycle.
module spi_in_sync (
    input  logic clk,
    input  logic reset,
    input  logic spc_i,
    input  logic cs_i,
    input  logic sdi_i,
    output logic sdi_o,
    output logic spc_rise_o,
    output logic spc_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);

    logic spc_s1_q, spc_s2_q, spc_prev_q;
    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic sdi_s1_q, sdi_s2_q;

    // Two-stage synchronisers plus one history stage for edge detection; idle levels on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            spc_s1_q   <= 1'b1;
            spc_s2_q   <= 1'b1;
            spc_prev_q <= 1'b1;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_prev_q  <= 1'b1;
            sdi_s1_q   <= 1'b0;
            sdi_s2_q   <= 1'b0;
        end else begin
            spc_s1_q   <= spc_i;
            spc_s2_q   <= spc_s1_q;
            spc_prev_q <= spc_s2_q;
            cs_s1_q    <= cs_i;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            sdi_s1_q   <= sdi_i;
            sdi_s2_q   <= sdi_s1_q;
        end
    end

    assign sdi_o      = sdi_s2_q;
    assign spc_rise_o = spc_s2_q & ~spc_prev_q;
    assign spc_fall_o = ~spc_s2_q & spc_prev_q;
    assign cs_fall_o  = ~cs_s2_q & cs_prev_q;
    assign cs_rise_o  = cs_s2_q & ~cs_prev_q;

endmodule

// File: rtl/spi_imu_responder.sv
// Purpose: SPI mode-3 target emulating the IMU register map (WHO_AM_I, control regs, sample snapshot).
// Latency: SDO updates 3 clk after a raw SPC fall; wr_valid pulses 3 clk after the 8th raw SPC rise of a data byte.
// Backpressure: none; the SPI master paces everything, write pulses cannot be stalled.
module spi_imu_responder
    import imu_regs_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    SPC,
    input  logic                    CS,
    input  logic                    SDI,
    output logic                    SDO,
    input  logic [OUT_BYTES*8-1:0]  sample_data,
    input  logic                    sample_valid,
    output logic [CTRL_COUNT*8-1:0] ctrl_out,
    output logic                    wr_valid,
    output logic [6:0]              wr_addr,
    output logic [7:0]              wr_data,
    output logic                    txn_active
);

    logic sdi_s, spc_rise, spc_fall, cs_fall, cs_rise;

    spi_in_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .spc_i      (SPC),
        .cs_i       (CS),
        .sdi_i      (SDI),
        .sdi_o      (sdi_s),
        .spc_rise_o (spc_rise),
        .spc_fall_o (spc_fall),
        .cs_fall_o  (cs_fall),
        .cs_rise_o  (cs_rise)
    );

    rsp_state_e                 state_q, state_d;
    logic [2:0]                 bitcnt_q, bitcnt_d;
    logic [7:0]                 shift_q, shift_d;
    logic [6:0]                 addr_q, addr_d;
    logic [7:0]                 tx_q, tx_d;
    logic                       sdo_q, sdo_d;
    logic [CTRL_COUNT*8-1:0]    ctrl_q, ctrl_d;
    logic [OUT_BYTES*8-1:0]     shadow_q, shadow_d;
    logic [OUT_BYTES*8-1:0]     pend_q, pend_d;
    logic                       pend_vld_q, pend_vld_d;
    logic                       wr_valid_q, wr_valid_d;
    logic [6:0]                 wr_addr_q, wr_addr_d;
    logic [7:0]                 wr_data_q, wr_data_d;
    logic [7:0]                 shifted;
    logic                       entering_idle;

    // Register-map read mux; unmapped addresses read as zero.
    function automatic logic [7:0] reg_read(input logic [6:0]             a,
                                            input logic [CTRL_COUNT*8-1:0] ctrl,
                                            input logic [OUT_BYTES*8-1:0]  shadow);
        logic [7:0] r;
        r = 8'h00;
        if (a == WHO_AM_I_ADDR) r = WHO_AM_I;
        for (int j = 0; j < CTRL_COUNT; j++)
            if (a == CTRL_BASE + 7'(j)) r = ctrl[8*j +: 8];
        for (int k = 0; k < OUT_BYTES; k++)
            if (a == OUT_BASE + 7'(k)) r = shadow[8*k +: 8];
        return r;
    endfunction

    assign shifted       = {shift_q[6:0], sdi_s};
    assign entering_idle = cs_rise && (state_q != IDLE);

    // Transaction FSM: command decode, read serialisation and write capture.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        sdo_d      = sdo_q;
        ctrl_d     = ctrl_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (entering_idle) begin
            // Any partial byte is simply dropped here.
            state_d  = IDLE;
            bitcnt_d = 3'd0;
            sdo_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d  = CMD;
                        bitcnt_d = 3'd0;
                    end
                end
                CMD: begin
                    if (spc_rise) begin
                        shift_d  = shifted;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            addr_d = shifted[6:0];
                            if (shifted[7]) begin
                                tx_d    = reg_read(shifted[6:0], ctrl_q, shadow_q);
                                state_d = READ;
                            end else begin
                                state_d = WRITE;
                            end
                        end
                    end
                end
                READ: begin
                    if (spc_fall) begin
                        sdo_d    = tx_q[3'd7 - bitcnt_q];
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            addr_d = addr_q + 7'd1;
                            tx_d   = reg_read(addr_q + 7'd1, ctrl_q, shadow_q);
                        end
                    end
                end
                WRITE: begin
                    if (spc_rise) begin
                        shift_d  = shifted;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            for (int j = 0; j < CTRL_COUNT; j++)
                                if (addr_q == CTRL_BASE + 7'(j)) ctrl_d[8*j +: 8] = shifted;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = shifted;
                            addr_d     = addr_q + 7'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Snapshot coherency: shadow only changes outside a transaction; strobes mid-transaction park in pending.
    always_comb begin
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (state_q == IDLE) begin
            if (sample_valid) shadow_d = sample_data;
        end else if (entering_idle) begin
            if (sample_valid)    shadow_d = sample_data;
            else if (pend_vld_q) shadow_d = pend_q;
            pend_vld_d = 1'b0;
        end else if (sample_valid) begin
            pend_d     = sample_data;
            pend_vld_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'h00;
            addr_q     <= 7'h00;
            tx_q       <= 8'h00;
            sdo_q      <= 1'b0;
            ctrl_q     <= '0;
            shadow_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 7'h00;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            sdo_q      <= sdo_d;
            ctrl_q     <= ctrl_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign SDO        = sdo_q;
    assign ctrl_out   = ctrl_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign txn_active = (state_q != IDLE);

endmodule

// File: tb/tb_spi_imu_responder.sv
// Purpose: directed self-checking bench acting as SPI mode-3 master against spi_imu_responder.
// Latency: SPI phases are 6 clk each; CS setup/hold 6 clk.
// Backpressure: n/a.
module tb_spi_imu_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SPC = 1'b1;
    logic        CS = 1'b1;
    logic        SDI = 1'b0;
    logic        SDO;
    logic [95:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic [79:0] ctrl_out;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        txn_active;

    int          checks = 0;
    int          failures = 0;
    int          wr_cnt = 0;
    int          w0;
    logic [6:0]  last_addr = '0;
    logic [7:0]  last_data = '0;
    logic [7:0]  m;
    logic [79:0] ctrl_exp;

    spi_imu_responder dut (
        .clk          (clk),
        .reset        (reset),
        .SPC          (SPC),
        .CS           (CS),
        .SDI          (SDI),
        .SDO          (SDO),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .ctrl_out     (ctrl_out),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .txn_active   (txn_active)
    );

    always #5 clk = ~clk;

    // Write-pulse monitor: count pulses and remember the last one.
    always @(posedge clk) begin
        if (wr_valid) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= wr_addr;
            last_data <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte (or fewer bits) MSB first: SDI changes with SPC low, SDO sampled as SPC rises.
    task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            SPC = 1'b0;
            SDI = mosi[i];
            clks(6);
            SPC = 1'b1;
            miso[i] = SDO;
            clks(6);
        end
    endtask

    task automatic cs_begin();
        CS = 1'b0;
        clks(6);
    endtask

    task automatic cs_end();
        CS = 1'b1;
        clks(8);
    endtask

    task automatic pulse_sample(input logic [95:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        clks(1);
        sample_valid = 1'b0;
    endtask

    initial begin
        // Reset state and quiet bus.
        clks(3);
        reset = 1'b0;
        clks(2);
        chk("rst_sdo", SDO, 0);
        chk("rst_ctrl", ctrl_out, 0);
        chk("rst_txn", txn_active, 0);
        w0 = wr_cnt;
        clks(20);
        chk("idle_no_wr", wr_cnt - w0, 0);

        // Single write 0x18 <- 0xE2.
        w0 = wr_cnt;
        cs_begin();
        xfer(8'h18, 8, m);
        chk("wr_txn_active", txn_active, 1);
        xfer(8'hE2, 8, m);
        cs_end();
        chk("wr18_count", wr_cnt - w0, 1);
        chk("wr18_addr", last_addr, 7'h18);
        chk("wr18_data", last_data, 8'hE2);
        chk("wr18_ctrl", ctrl_out[71:64], 8'hE2);
        chk("wr18_txn_done", txn_active, 0);

        // WHO_AM_I read.
        cs_begin();
        xfer(8'h8F, 8, m);
        xfer(8'h00, 8, m);
        cs_end();
        chk("whoami", m, 8'h6C);

        // Burst write with auto-increment.
        w0 = wr_cnt;
        cs_begin();
        xfer(8'h10, 8, m);
        xfer(8'h60, 8, m);
        xfer(8'h60, 8, m);
        cs_end();
        chk("burst_wr_count", wr_cnt - w0, 2);
        chk("burst_wr_ctrl_lo", ctrl_out[15:0], 16'h6060);
        ctrl_exp = {8'h00, 8'hE2, 48'h0, 16'h6060};
        chk("burst_wr_ctrl_all", ctrl_out, ctrl_exp);

        // Snapshot taken in IDLE, then 13-byte burst read from 0x22.
        pulse_sample(96'h0C0B0A090807060504030201);
        clks(2);
        cs_begin();
        xfer(8'hA2, 8, m);
        for (int k = 0; k < 13; k++) begin
            xfer(8'h00, 8, m);
            chk($sformatf("snap_b%0d", k), m, (k < 12) ? 8'(k + 1) : 8'h00);
        end
        cs_end();

        // New sample mid-burst must not disturb the burst in flight.
        cs_begin();
        xfer(8'hA2, 8, m);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) pulse_sample(96'hABAAA9A8A7A6A5A4A3A2A1A0);
            xfer(8'h00, 8, m);
            chk($sformatf("coh_old_b%0d", k), m, 8'(k + 1));
        end
        cs_end();
        cs_begin();
        xfer(8'hA2, 8, m);
        for (int k = 0; k < 4; k++) begin
            xfer(8'h00, 8, m);
            chk($sformatf("coh_new_b%0d", k), m, 8'hA0 + 8'(k));
        end
        cs_end();

        // Partial write byte to 0x11 is discarded.
        w0 = wr_cnt;
        cs_begin();
        xfer(8'h11, 8, m);
        xfer(8'hFF, 5, m);
        cs_end();
        chk("partial_no_wr", wr_cnt - w0, 0);
        chk("partial_ctrl", ctrl_out, ctrl_exp);

        // Write into the OUT range: pulse reported, contents untouched.
        w0 = wr_cnt;
        cs_begin();
        xfer(8'h22, 8, m);
        xfer(8'h55, 8, m);
        cs_end();
        chk("out_wr_count", wr_cnt - w0, 1);
        chk("out_wr_addr", last_addr, 7'h22);
        chk("out_wr_data", last_data, 8'h55);
        chk("out_wr_ctrl", ctrl_out, ctrl_exp);
        cs_begin();
        xfer(8'hA2, 8, m);
        xfer(8'h00, 8, m);
        cs_end();
        chk("out_readback", m, 8'hA0);

        // Reset in the middle of a read.
        cs_begin();
        xfer(8'h8F, 8, m);
        xfer(8'h00, 3, m);
        chk("mid_read_sdo", SDO, 1);
        reset = 1'b1;
        clks(2);
        chk("mid_rst_sdo", SDO, 0);
        chk("mid_rst_txn", txn_active, 0);
        chk("mid_rst_ctrl", ctrl_out, 0);
        reset = 1'b0;
        cs_end();
        chk("post_rst_txn", txn_active, 0);
        cs_begin();
        xfer(8'h8F, 8, m);
        xfer(8'h00, 8, m);
        cs_end();
        chk("post_rst_whoami", m, 8'h6C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_imu_responder.md
Name: spi_imu_responder

Overview:
- SPI peripheral model of the IMU register interface: the target side of the IMU init/burst-read master.
- Oversamples SPC/CS/SDI on clk and decodes 8-bit command bytes (R/W + 7-bit address).
- Serves reads from a small register map with a coherent 96-bit sample snapshot, and accepts control-register writes.
- Used as an on-chip loopback/emulation target and as the bench model for the master.

Parameters:
- WHO_AM_I, 8'h6C, read-only value at address 0x0F.
- CTRL_BASE, 7'h10, first writable control register.
- CTRL_COUNT, 10, number of writable control registers (0x10..0x19).
- OUT_BASE, 7'h22, first sample-data register.
- OUT_BYTES, 12, sample-data bytes (0x22..0x2D).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- SPC  input  1  SPI clock from master, idle high.
- CS  input  1  chip select, active low.
- SDI  input  1  master-to-peripheral data.
- SDO  output  1  peripheral-to-master data.
- sample_data  input  96  byte k at address OUT_BASE+k is sample_data[8k+7:8k].
- sample_valid  input  1  one-cycle strobe, new sample available.
- ctrl_out  output  80  control registers; byte j holds address CTRL_BASE+j.
- wr_valid  output  1  one-cycle pulse per accepted write byte.
- wr_addr  output  7  address of the accepted write.
- wr_data  output  8  data of the accepted write.
- txn_active  output  1  high while a transaction is in progress (state != IDLE).

Behaviour:
- Protocol: SPI mode 3, MSB first.
  - Master changes SDI on SPC falling edges; the block samples on rising edges.
  - The block updates SDO on falling edges.
  - Command byte: bit7=1 read, 0 write; bits 6:0 address.
- Synchronisation:
  - SPC, CS, SDI each pass through 2 flip-flops. Reset values: SPC=1, CS=1, SDI=0.
  - Edge flags are derived from the synced signals: spc_rise, spc_fall, cs_fall, cs_rise.
  - Timing requirement: SPC high and low phases ≥4 clk each; CS setup/hold to SPC ≥4 clk.
  - SDO changes exactly 3 clk after a raw SPC falling edge.
- States:
  - IDLE: cs_fall -> CMD; clear bit counter.
  - CMD: shift SDI on each spc_rise. On the 8th bit, latch rw and addr.
    - Read: load tx = reg[addr]; go to READ.
    - Write: go to WRITE.
  - READ: on each spc_fall, SDO <= tx[7-bitcnt], bitcnt++. On the 8th falling edge (bit0 driven): addr <= addr+1 (7-bit wrap 0x7F->0x00), tx <= reg[addr+1].
  - WRITE: shift SDI on spc_rise. On the 8th bit:
    - If addr is in CTRL range, write the register.
    - Pulse wr_valid for 1 cycle with wr_addr/wr_data, for any address.
    - addr++ (same wrap rule).
  - Any state: cs_rise -> IDLE. A partial byte is discarded with no write and no wr_valid; bitcnt=0.
- SDO is 0 in IDLE, CMD and WRITE, and is forced to 0 on entering IDLE.
- Read map:
  - 0x0F -> WHO_AM_I.
  - CTRL range -> stored value.
  - OUT range -> shadow snapshot byte.
  - All others -> 0x00.
- Writes outside the CTRL range (including 0x0F and the OUT range) do not change state.
- Snapshot coherency:
  - sample_valid while in IDLE: shadow <= sample_data next cycle.
  - sample_valid while txn_active: data goes to a pending register with pending=1; the latest strobe wins.
  - On the cycle of entering IDLE, a pending value is copied to shadow and pending is cleared.
  - If sample_valid coincides with entering IDLE, the new sample_data takes priority.
- Reset: state IDLE, SDO=0, ctrl regs=0, shadow=0, pending=0, wr_valid=0, wr_addr=0, wr_data=0, txn_active=0. Reset mid-transaction aborts with no write.

Decomposition:
- Package imu_regs_pkg holds:
  - address constants: WHO_AM_I_ADDR=0x0F, CTRL_BASE, CTRL_COUNT, OUT_BASE, OUT_BYTES, and the master's used addresses 0x10, 0x11, 0x13, 0x18, 0x22;
  - the responder state enum (IDLE, CMD, READ, WRITE).
- Sub-module spi_in_sync: 2-FF synchronisers for SPC/CS/SDI plus edge flags. Instantiated once.

Test Plan:
- Reset -> SDO=0, ctrl_out=80'h0, txn_active=0, wr_valid never pulses while CS stays high.
- Write cmd 0x18, data 0xE2 -> one wr_valid with wr_addr=0x18, wr_data=0xE2; ctrl_out[71:64]=0xE2; txn_active low after CS rise.
- Read cmd 0x8F + 8 SPC cycles -> master samples 0x6C. Burst-write 0x10: 0x60,0x60 -> ctrl_out[15:0]=16'h6060 (auto-increment).
- sample_valid with sample_data=96'h0C0B0A090807060504030201, then read cmd 0xA2 + 12 bytes -> SDO bytes 01,02,...,0C; a 13th byte from 0x2E reads 00.
- sample_valid with new data during byte 3 of a burst -> remainder of the burst returns old bytes; next burst returns new bytes.
- CS released after 5 data bits of a write to 0x11 -> no wr_valid, ctrl unchanged. Write 0x55 to 0x22 -> wr_valid pulses, readback unchanged. Reset asserted mid-read -> SDO=0, IDLE.
